// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: on-chip self-test driving a registered ALU through all 4 ops.
// Optional error counter/mask outputs are enabled by defining ALU_SEQ_ERRCNT_EN.
module alu_op_sequencer #(
    parameter int W    = 4,
    parameter int HOLD = 3,
    parameter int LAT  = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [1:0]     alu_sel,
    input  logic [W-1:0]   alu_g,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [4*W-1:0] results
`ifdef ALU_SEQ_ERRCNT_EN
    ,
    output logic [2:0]     err_cnt,
    output logic [3:0]     err_mask
`endif
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if (HOLD < LAT + 1) begin : g_hold_chk
        $error("HOLD must be at least LAT+1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]       op_idx_q, op_idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [4*W-1:0]   results_q, results_d;
    logic             pass_acc_q, pass_acc_d;
    logic             pass_q, pass_d;
    logic [W-1:0]     gold;
    logic             mismatch;
    logic             last_hold;
`ifdef ALU_SEQ_ERRCNT_EN
    logic [2:0]       err_cnt_q, err_cnt_d;
    logic [3:0]       err_mask_q, err_mask_d;
`endif

    // Golden result for the op currently held on the ALU.
    always_comb begin
        gold = '0;
        unique case (op_idx_q)
            2'd0: gold = a_q + b_q;
            2'd1: gold = a_q - b_q;
            2'd2: gold = a_q & b_q;
            2'd3: gold = a_q | b_q;
            default: gold = '0;
        endcase
    end

    assign mismatch  = (alu_g != gold);
    assign last_hold = (hold_cnt_q == CW'(HOLD - 1));

    // Next-state logic: accept start, sweep the four ops, report.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        op_idx_d   = op_idx_q;
        a_d        = a_q;
        b_d        = b_q;
        results_d  = results_q;
        pass_acc_d = pass_acc_q;
        pass_d     = pass_q;
`ifdef ALU_SEQ_ERRCNT_EN
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    a_d        = a_in;
                    b_d        = b_in;
                    op_idx_d   = 2'd0;
                    hold_cnt_d = '0;
                    results_d  = '0;
                    pass_acc_d = 1'b1;
                    pass_d     = 1'b0;
`ifdef ALU_SEQ_ERRCNT_EN
                    err_cnt_d  = '0;
                    err_mask_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (last_hold) begin
                    for (int k = 0; k < 4; k++) begin
                        if (op_idx_q == 2'(k)) begin
                            results_d[k*W +: W] = alu_g;
`ifdef ALU_SEQ_ERRCNT_EN
                            if (mismatch) err_mask_d[k] = 1'b1;
`endif
                        end
                    end
                    if (mismatch) begin
                        pass_acc_d = 1'b0;
`ifdef ALU_SEQ_ERRCNT_EN
                        err_cnt_d  = err_cnt_q + 3'd1;
`endif
                    end
                    if (op_idx_q != 2'd3) begin
                        op_idx_d   = op_idx_q + 2'd1;
                        hold_cnt_d = '0;
                    end else begin
                        // pass is published together with done
                        state_d = S_DONE;
                        pass_d  = pass_acc_q & ~mismatch;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            op_idx_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            results_q  <= '0;
            pass_acc_q <= 1'b0;
            pass_q     <= 1'b0;
`ifdef ALU_SEQ_ERRCNT_EN
            err_cnt_q  <= '0;
            err_mask_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            op_idx_q   <= op_idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            results_q  <= results_d;
            pass_acc_q <= pass_acc_d;
            pass_q     <= pass_d;
`ifdef ALU_SEQ_ERRCNT_EN
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
`endif
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = op_idx_q;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign pass    = pass_q;
    assign results = results_q;
`ifdef ALU_SEQ_ERRCNT_EN
    assign err_cnt  = err_cnt_q;
    assign err_mask = err_mask_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table vectors, corner sequences and random runs
// against a behavioural model of the self-test sequencer.
module tb_alu_op_sequencer;

    localparam int W    = 4;
    localparam int HOLD = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   a_in = '0;
    logic [3:0]   b_in = '0;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [1:0]   alu_sel;
    logic [3:0]   alu_g = '0;
    logic         busy;
    logic         done;
    logic         pass;
    logic [15:0]  results;
`ifdef ALU_SEQ_ERRCNT_EN
    logic [2:0]   err_cnt;
    logic [3:0]   err_mask;
`endif

    logic [3:0]   zero_mask = '0;
    int           total = 0;
    int           bad = 0;

    alu_op_sequencer #(.W(W), .HOLD(HOLD), .LAT(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_g   (alu_g),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .results (results)
`ifdef ALU_SEQ_ERRCNT_EN
        ,
        .err_cnt (err_cnt),
        .err_mask(err_mask)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] op_val(input int k, input logic [3:0] a, b);
        int r;
        case (k)
            0: r = (int'(a) + int'(b)) % 16;
            1: r = (int'(a) - int'(b) + 16) % 16;
            2: r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 4'(r);
    endfunction

    // External registered ALU, one cycle latency, with fault injection
    always @(posedge clk) begin
        if (zero_mask[alu_sel]) alu_g <= 4'd0;
        else alu_g <= op_val(int'(alu_sel), alu_a, alu_b);
    end

    function automatic logic [15:0] model_res(input logic [3:0] a, b, zm);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[k*4 +: 4] = zm[k] ? 4'd0 : op_val(k, a, b);
        return r;
    endfunction

    function automatic logic [3:0] model_errs(input logic [3:0] a, b, zm);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++)
            m[k] = zm[k] && (op_val(k, a, b) != 4'd0);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [3:0] a, b, zm,
                       input int restart_at, input int reset_at,
                       output int done_cyc, output int ndone,
                       output int busy_cnt, output int sel_bad);
        zero_mask = zm;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        done_cyc = 0;
        ndone    = 0;
        busy_cnt = 0;
        sel_bad  = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (busy) busy_cnt++;
            if (reset_at == 0 && n <= 4 * HOLD && alu_sel != 2'((n - 1) / HOLD))
                sel_bad++;
            if (reset_at > 0 && n == reset_at + 1) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_sel", 32'(alu_sel), 0);
                chk("rst_results", 32'(results), 0);
                chk("rst_alu_a", 32'(alu_a), 0);
                chk("rst_pass", 32'(pass), 0);
                reset = 1'b0;
            end
            if (n == restart_at) begin
                a_in  = ~a;
                b_in  = a ^ b ^ 4'h9;
                start = 1'b1;
            end
            if (n == reset_at) reset = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  zm;
        logic [15:0] exp_res;
        logic        exp_pass;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs[7];

    task automatic check_run(input string tag, input logic [3:0] a, b,
                             input logic [15:0] er, input logic ep,
                             input logic [3:0] em, input int dc, input int nd,
                             input int bc, input int sb);
        chk({tag, "_done_cyc"}, 32'(dc), 32'(4 * HOLD + 1));
        chk({tag, "_ndone"}, 32'(nd), 1);
        chk({tag, "_busy_cnt"}, 32'(bc), 32'(4 * HOLD));
        chk({tag, "_sel_seq"}, 32'(sb), 0);
        chk({tag, "_results"}, 32'(results), 32'(er));
        chk({tag, "_pass"}, 32'(pass), 32'(ep));
        chk({tag, "_alu_ab"}, {24'd0, alu_a, alu_b}, {24'd0, a, b});
`ifdef ALU_SEQ_ERRCNT_EN
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'($countones(em)));
        chk({tag, "_err_mask"}, 32'(err_mask), 32'(em));
`else
        if (em == 4'hF && ep) chk({tag, "_mask_pass"}, 32'(pass), 0);
`endif
    endtask

    initial begin
        int dc, nd, bc, sb;
        logic [3:0] ra, rb, rz;

        vecs[0] = '{4'h5, 4'h3, 4'h0, 16'h7128, 1'b1, 4'h0};
        vecs[1] = '{4'hF, 4'h1, 4'h0, 16'hF1E0, 1'b1, 4'h0};
        vecs[2] = '{4'h3, 4'h5, 4'h0, 16'h71E8, 1'b1, 4'h0};
        vecs[3] = '{4'hF, 4'hF, 4'h0, 16'hFF0E, 1'b1, 4'h0};
        vecs[4] = '{4'h0, 4'h0, 4'h0, 16'h0000, 1'b1, 4'h0};
        vecs[5] = '{4'hA, 4'h6, 4'h0, 16'hE240, 1'b1, 4'h0};
        vecs[6] = '{4'h5, 4'h3, 4'h4, 16'h7028, 1'b0, 4'h4};

        repeat (3) @(negedge clk);
        chk("reset_outs", {15'd0, busy, done, pass, alu_sel, alu_a, alu_b, 4'd0},
            32'd0);
        chk("reset_results", 32'(results), 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].b, vecs[i].zm, 0, 0, dc, nd, bc, sb);
            check_run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                      vecs[i].exp_res, vecs[i].exp_pass, vecs[i].exp_mask,
                      dc, nd, bc, sb);
        end

        // start again mid-run with new operands: ignored
        run(4'h5, 4'h3, 4'h0, 5, 0, dc, nd, bc, sb);
        check_run("restart", 4'h5, 4'h3, 16'h7128, 1'b1, 4'h0, dc, nd, bc, sb);

        // reset mid-run: no done pulse, state cleared
        run(4'h5, 4'h3, 4'h0, 0, 7, dc, nd, bc, sb);
        chk("abort_ndone", 32'(nd), 0);
        chk("abort_idle", 32'(busy), 0);
        run(4'h9, 4'h4, 4'h0, 0, 0, dc, nd, bc, sb);
        check_run("after_abort", 4'h9, 4'h4, model_res(4'h9, 4'h4, 4'h0),
                  1'b1, 4'h0, dc, nd, bc, sb);

        // start together with reset: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        a_in  = 4'hC;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 0);
        chk("rst_start_a", 32'(alu_a), 0);
        @(negedge clk);
        chk("rst_start_busy2", 32'(busy), 0);
        chk("rst_start_done", 32'(done), 0);

        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rz = 4'($urandom) & 4'($urandom);
            run(ra, rb, rz, 0, 0, dc, nd, bc, sb);
            check_run($sformatf("rnd%0d", i), ra, rb, model_res(ra, rb, rz),
                      model_errs(ra, rb, rz) == 4'h0, model_errs(ra, rb, rz),
                      dc, nd, bc, sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
